// File: rtl/pic_gpio_bank.sv
// Purpose: PIC-style GPIO bank with PORT/TRIS/IOC registers, pad synchronizers and interrupt-on-change flags.
// Latency: writes take effect on the next clk edge, reads are combinational, pad changes reach sync after 2 edges, and flags follow sync by 1 edge.
// Backpressure: none; every access completes in the cycle it is presented.
module pic_gpio_bank #(
    parameter int         NUM_PORTS      = 2,
    parameter int         WIDTH          = 8,
    parameter logic [8:0] PORT_BASE_ADDR = 9'h005,
    parameter logic [8:0] TRIS_BASE_ADDR = 9'h085,
    parameter logic [8:0] IOC_BASE_ADDR  = 9'h096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [8:0]                 addr,
    input  logic                       wr_en,
    input  logic                       rd_en,
    input  logic [7:0]                 data_in,
    output logic [7:0]                 data_out,
    input  logic [NUM_PORTS*WIDTH-1:0] phy_in,
    output logic [NUM_PORTS*WIDTH-1:0] phy_out,
    output logic [NUM_PORTS*WIDTH-1:0] phy_oe,
    output logic [NUM_PORTS-1:0]       ioc_flags,
    output logic                       ioc_strobe
);

    localparam int NW = NUM_PORTS * WIDTH;

    // Architectural registers, all ports packed side by side
    logic [NW-1:0]        r_port;
    logic [NW-1:0]        r_tris;
    logic [NW-1:0]        r_ioc;
    logic [NW-1:0]        r_ref;
    logic [NW-1:0]        r_sync1;
    logic [NW-1:0]        r_sync2;
    logic [NUM_PORTS-1:0] r_flags;
    logic                 r_strobe;

    // Decode and per-port derived values
    logic [NUM_PORTS-1:0] w_port_hit;
    logic [NUM_PORTS-1:0] w_tris_hit;
    logic [NUM_PORTS-1:0] w_ioc_hit;
    logic [NUM_PORTS-1:0] w_rd_port;
    logic [NUM_PORTS-1:0] w_mis;
    logic [NUM_PORTS-1:0] w_flags_nxt;
    logic [NW-1:0]        w_port_val;
    logic [7:0]           w_rd;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        localparam int LO = g * WIDTH;

        assign w_port_hit[g] = (addr == 9'(PORT_BASE_ADDR + g));
        assign w_tris_hit[g] = (addr == 9'(TRIS_BASE_ADDR + g));
        assign w_ioc_hit[g]  = (addr == 9'(IOC_BASE_ADDR + g));

        // Input pins show the synchronized pad, output pins show the latch
        assign w_port_val[LO +: WIDTH] = (r_tris[LO +: WIDTH] & r_sync2[LO +: WIDTH])
                                       | (~r_tris[LO +: WIDTH] & r_port[LO +: WIDTH]);

        // Only IOC-enabled input pins can raise a mismatch
        assign w_mis[g] = |(r_ioc[LO +: WIDTH] & r_tris[LO +: WIDTH]
                            & (r_sync2[LO +: WIDTH] ^ r_ref[LO +: WIDTH]));

        assign w_rd_port[g] = rd_en & w_port_hit[g];

        // A PORT read clears the flag and wins over a concurrent mismatch
        assign w_flags_nxt[g] = ~w_rd_port[g] & (r_flags[g] | w_mis[g]);
    end

    // Combinational read mux; unmapped addresses and unused upper bits read zero
    always_comb begin
        w_rd = 8'h00;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_port_hit[i]) w_rd[WIDTH-1:0] = w_port_val[i*WIDTH +: WIDTH];
            if (w_tris_hit[i]) w_rd[WIDTH-1:0] = r_tris[i*WIDTH +: WIDTH];
            if (w_ioc_hit[i])  w_rd[WIDTH-1:0] = r_ioc[i*WIDTH +: WIDTH];
        end
    end

    // Register writes from the core; upper data bits beyond WIDTH are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_port <= '0;
            r_tris <= '1;
            r_ioc  <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_port_hit[i]) r_port[i*WIDTH +: WIDTH] <= data_in[WIDTH-1:0];
                if (w_tris_hit[i]) r_tris[i*WIDTH +: WIDTH] <= data_in[WIDTH-1:0];
                if (w_ioc_hit[i])  r_ioc[i*WIDTH +: WIDTH]  <= data_in[WIDTH-1:0];
            end
        end
    end

    // Two-flop pad synchronizer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= phy_in;
            r_sync2 <= r_sync1;
        end
    end

    // Change reference, sticky flags and single-cycle strobe on any flag rise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ref    <= '0;
            r_flags  <= '0;
            r_strobe <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_rd_port[i]) r_ref[i*WIDTH +: WIDTH] <= r_sync2[i*WIDTH +: WIDTH];
            end
            r_flags  <= w_flags_nxt;
            r_strobe <= |(w_flags_nxt & ~r_flags);
        end
    end

    assign data_out   = w_rd;
    assign phy_out    = r_port;
    assign phy_oe     = ~r_tris;
    assign ioc_flags  = r_flags;
    assign ioc_strobe = r_strobe;

endmodule
